// File: rtl/rescap_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rescap_ctrl_pkg
// Purpose  : Shared types and default widths for the supply sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rescap_ctrl_pkg;

    localparam int C_CODE_W   = 8;
    localparam int C_SETTLE_W = 16;
    localparam int C_RES_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_MEAS   = 3'd2,
        ST_STEP   = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_t;

    typedef struct packed {
        logic [C_CODE_W-1:0] code;
        logic [C_RES_W-1:0]  data;
    } meas_result_t;

endpackage
`default_nettype wire

// File: rtl/rescap_sweep_ctrl_meas_hs.sv
`default_nettype none
// ============================================================================
// Module   : rescap_meas_hs
// Purpose  : Probe req/ack handshake with ack timeout and result capture.
// Revision : 1.0 - initial release
// ============================================================================
module rescap_meas_hs
    import rescap_ctrl_pkg::*;
#(
    parameter int CODE_W      = C_CODE_W,
    parameter int RES_W       = C_RES_W,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_launch,
    input  logic              i_abort,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_meas_ack,
    input  logic [RES_W-1:0]  i_meas_data,
    output logic              o_meas_req,
    output logic              o_ack_seen,
    output logic              o_timeout,
    output logic              o_res_valid,
    output logic              o_err_timeout,
    output logic [CODE_W-1:0] o_res_code,
    output logic [RES_W-1:0]  o_res_data
);

    localparam int              TO_W        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] C_WAIT_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic            r_req;
    logic [TO_W-1:0] r_wait;
    logic            r_res_valid;
    logic            r_err_timeout;
    meas_result_t    r_res;

    // ack is only meaningful while a request is outstanding
    assign o_ack_seen = r_req & i_meas_ack;
    assign o_timeout  = r_req & ~i_meas_ack & (r_wait == C_WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req         <= 1'b0;
            r_wait        <= '0;
            r_res_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_res         <= '0;
        end else begin
            r_res_valid   <= 1'b0;
            r_err_timeout <= 1'b0;
            if (i_abort) begin
                r_req <= 1'b0;
            end else if (i_launch) begin
                r_req  <= 1'b1;
                r_wait <= '0;
            end else if (r_req) begin
                if (i_meas_ack) begin
                    r_req       <= 1'b0;
                    r_res_valid <= 1'b1;
                    r_res       <= '{code: C_CODE_W'(i_code), data: C_RES_W'(i_meas_data)};
                end else if (r_wait == C_WAIT_LAST) begin
                    r_req         <= 1'b0;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_wait <= r_wait + TO_W'(1);
                end
            end
        end
    end

    assign o_meas_req    = r_req;
    assign o_res_valid   = r_res_valid;
    assign o_err_timeout = r_err_timeout;
    assign o_res_code    = CODE_W'(r_res.code);
    assign o_res_data    = RES_W'(r_res.data);

endmodule
`default_nettype wire

// File: rtl/rescap_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rescap_sweep_ctrl
// Purpose  : Steps the supply DAC code, settles, and requests one probe
//            measurement per step.
// Revision : 1.0 - initial release
// ============================================================================
module rescap_sweep_ctrl
    import rescap_ctrl_pkg::*;
#(
    parameter int CODE_W      = C_CODE_W,
    parameter int SETTLE_W    = C_SETTLE_W,
    parameter int RES_W       = C_RES_W,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CODE_W-1:0]   cfg_start_code,
    input  logic [CODE_W-1:0]   cfg_stop_code,
    input  logic [CODE_W-1:0]   cfg_step,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic                meas_ack,
    input  logic [RES_W-1:0]    meas_data,
    output logic [CODE_W-1:0]   dac_code,
    output logic                dac_en,
    output logic                meas_req,
    output logic                res_valid,
    output logic [CODE_W-1:0]   res_code,
    output logic [RES_W-1:0]    res_data,
    output logic                busy,
    output logic                done,
    output logic                err_cfg,
    output logic                err_timeout
);

    sweep_state_t        r_state;
    sweep_state_t        w_state_nxt;
    logic [CODE_W-1:0]   r_stop;
    logic [CODE_W-1:0]   r_step;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_cnt;
    logic [CODE_W-1:0]   r_dac_code;
    logic                r_dac_en;
    logic                r_done;
    logic                r_err_cfg;

    logic                w_accept;
    logic                w_cfg_bad;
    logic                w_launch;
    logic                w_advance;
    logic                w_finish;
    logic                w_kill;
    logic                w_ack_seen;
    logic                w_timeout;
    logic [CODE_W:0]     w_sum;

    // one extra bit so a step past the top code cannot wrap back into range
    assign w_sum = {1'b0, r_dac_code} + {1'b0, r_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cfg_bad   = 1'b0;
        w_launch    = 1'b0;
        w_advance   = 1'b0;
        w_finish    = 1'b0;
        w_kill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_step == '0) || (cfg_start_code > cfg_stop_code)) begin
                        w_cfg_bad = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_kill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == r_settle) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_MEAS;
                end
            end
            ST_MEAS: begin
                if (abort || w_timeout) begin
                    w_kill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_ack_seen) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    w_kill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_sum > {1'b0, r_stop}) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_kill      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop     <= '0;
            r_step     <= '0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_dac_code <= '0;
            r_dac_en   <= 1'b0;
            r_done     <= 1'b0;
            r_err_cfg  <= 1'b0;
        end else begin
            r_done    <= w_finish;
            r_err_cfg <= w_cfg_bad;
            if (w_accept) begin
                r_stop     <= cfg_stop_code;
                r_step     <= cfg_step;
                r_settle   <= cfg_settle;
                r_cnt      <= '0;
                r_dac_code <= cfg_start_code;
                r_dac_en   <= 1'b1;
            end else if (w_kill || w_finish) begin
                r_dac_code <= '0;
                r_dac_en   <= 1'b0;
            end else if (w_advance) begin
                r_dac_code <= w_sum[CODE_W-1:0];
                r_cnt      <= '0;
            end else if (r_state == ST_SETTLE) begin
                r_cnt <= r_cnt + SETTLE_W'(1);
            end
        end
    end

    rescap_meas_hs #(
        .CODE_W      (CODE_W),
        .RES_W       (RES_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_meas_hs (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_launch      (w_launch),
        .i_abort       (abort),
        .i_code        (r_dac_code),
        .i_meas_ack    (meas_ack),
        .i_meas_data   (meas_data),
        .o_meas_req    (meas_req),
        .o_ack_seen    (w_ack_seen),
        .o_timeout     (w_timeout),
        .o_res_valid   (res_valid),
        .o_err_timeout (err_timeout),
        .o_res_code    (res_code),
        .o_res_data    (res_data)
    );

    assign dac_code = r_dac_code;
    assign dac_en   = r_dac_en;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign err_cfg  = r_err_cfg;

endmodule
`default_nettype wire

// File: doc/rescap_sweep_ctrl.md
Name: rescap_sweep_ctrl

Overview:
- Digital sequencer for the supply sweep of the resistor-capacitor bench.
- Steps a supply DAC code from a start value to a stop value. At each step it waits a programmable settle time, then requests one measurement from the analog probe over a req/ack handshake and reports the result.
- Sits between the test harness (configuration, start/abort) and the real-valued supply driver and probe wrapper. Code-to-voltage conversion happens outside this block.

Parameters:
- CODE_W, 8, width of DAC code and of sweep start/stop/step.
- SETTLE_W, 16, width of settle-cycle counter.
- RES_W, 12, width of probe measurement result.
- ACK_TIMEOUT, 1024, maximum cycles meas_req may wait for meas_ack.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a sweep (honoured in IDLE only).
- abort  input  1  level; terminates the sweep.
- cfg_start_code  input  CODE_W  first DAC code.
- cfg_stop_code  input  CODE_W  last permitted DAC code.
- cfg_step  input  CODE_W  code increment.
- cfg_settle  input  SETTLE_W  settle cycles per step.
- meas_ack  input  1  single-cycle acknowledge from probe.
- meas_data  input  RES_W  probe result, valid with meas_ack.
- dac_code  output  CODE_W  supply code.
- dac_en  output  1  supply driven; low means supply at 0.
- meas_req  output  1  measurement request.
- res_valid  output  1  one-cycle result strobe.
- res_code  output  CODE_W  DAC code of the reported result.
- res_data  output  RES_W  captured measurement.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle sweep-complete pulse.
- err_cfg  output  1  one-cycle pulse on rejected config.
- err_timeout  output  1  one-cycle pulse on ack timeout.

Behaviour:
Clock and reset:
- One clock.
- Reset is asynchronous and active-low.
- All outputs are 0 in reset. State resets to IDLE.

States: IDLE, SETTLE, MEAS, STEP, DONE.

IDLE:
- On start, the config inputs are checked.
- If cfg_step==0 or cfg_start_code>cfg_stop_code: err_cfg pulses next cycle and the block stays in IDLE.
- Otherwise all cfg values are latched (later config changes are ignored), dac_code=cfg_start_code, dac_en=1, settle counter cleared, next state SETTLE.

SETTLE:
- The counter increments each cycle.
- When counter==latched settle, go to MEAS. With settle=0, SETTLE lasts exactly one cycle.

MEAS:
- meas_req=1 is held until meas_ack is sampled high. The block does not sample ack before req is asserted.
- On ack: meas_data is captured into res_data, res_code=dac_code, and res_valid pulses the following cycle. meas_req drops in the cycle after ack. Next state STEP.
- If ack does not arrive within ACK_TIMEOUT cycles of req assertion: err_timeout pulses, meas_req drops, dac_code=0, dac_en=0, next state IDLE. done does not pulse.

STEP (one cycle):
- next = dac_code + step, computed at CODE_W+1 bits so there is no wrap.
- If next > latched stop, go to DONE.
- Otherwise dac_code=next, counter cleared, go to SETTLE.
- The last measured code is the largest start + k·step that is ≤ stop.

DONE (one cycle):
- done=1, dac_code=0, dac_en=0, then IDLE.

Abort:
- Abort in any non-IDLE state forces IDLE on the next edge: meas_req=0, dac_code=0, dac_en=0.
- No done and no res_valid are produced for an ack arriving in the same cycle as abort.
- Abort takes priority over all transitions. Abort in IDLE with start at the same time: start is ignored.

Other rules:
- start while busy is ignored.
- A reset assertion mid-sweep returns all outputs to 0 immediately, asynchronously.
- busy=1 in SETTLE, MEAS, STEP and DONE.

Decomposition:
- Package rescap_ctrl_pkg holds: the state enum (sweep_state_t), default widths CODE_W/SETTLE_W/RES_W, and a result struct {code, data}.
- One natural sub-module: rescap_meas_hs. It owns the req/ack handshake, the timeout counter, and result capture, and reports ack_seen/timeout back to the FSM.

Test Plan:
- Basic sweep: start=10, stop=40, step=10, settle=3, probe acks 2 cycles after req → res_code sequence 10,20,30,40; 4 res_valid pulses; SETTLE lasts 4 cycles per step; done pulses once; dac_en low afterwards.
- Overshoot / no wrap: start=250, stop=255, step=4, CODE_W=8 → results at 250 and 254 only; dac_code never shows a wrapped value (2); done pulses.
- Config reject: step=0 → err_cfg pulse, busy stays 0. Separately start=50, stop=20 → err_cfg pulse, no meas_req.
- Timeout: probe never acks, ACK_TIMEOUT=16 → err_timeout exactly 16 cycles after meas_req rises; dac_code=0, busy=0, no done.
- Abort mid-MEAS, with ack in the same cycle → no res_valid, no done, meas_req low next cycle, block returns to IDLE.
- rst_n asserted during SETTLE → all outputs 0 without waiting for a clock edge; a fresh start afterwards sweeps normally.
